controle_multiciclo: RTL and testbench

Main control unit for the multicycle MIPS datapath. A Moore finite state machine, with write enables qualified by the memory handshake, that sequences fetch, decode, execute, memory and write-back. It drives every datapath select, including the MemToReg select of the write-back multiplexer, and the write enables of the PC, IR, register file and memory. It also keeps a retired-instruction counter for debug.

---
 rtl/controle_multiciclo_pkg.sv | 40 ++++
 rtl/controle_multiciclo.sv | 173 +++++++++++++++++
 tb/tb_controle_multiciclo.sv | 135 +++++++++++++
 3 files changed

// File: rtl/controle_multiciclo_pkg.sv
// Shared MIPS control definitions: opcodes, FSM state encoding and datapath select codes.
// The datapath muxes import the same constants so both sides agree on the encodings.
package controle_multiciclo_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } estado_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_4       = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS main control: Moore FSM with memory-handshake-qualified enables
// and a retired-instruction counter for debug.
//
// state    | meaning
// FETCH    | read instruction at PC, load IR and PC+4 when memory is ready
// DECODE   | register read, branch target into ALUOut
// MEMADR   | effective address for lw/sw
// MEMREAD  | data read, waits on mem_pronto
// MEMWB    | load result into rt
// MEMWRITE | data write, waits on mem_pronto
// EXECUTE  | R-type ALU operation
// ALUWB    | R-type result into rd
// BRANCH   | beq compare and conditional PC load
// ADDIEXEC | addi ALU operation
// ADDIWB   | addi result into rt
// JUMP     | PC load from jump target
module controle_multiciclo
    import controle_multiciclo_pkg::*;
#(
    parameter int LARGURA_CONT = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5:0]              opcode,
    input  logic                    mem_pronto,
    output logic                    mem_req,
    output logic                    MemWrite,
    output logic                    IorD,
    output logic                    IRWrite,
    output logic                    PCWrite,
    output logic                    Branch,
    output logic [1:0]              PCSrc,
    output logic                    ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [1:0]              ALUOp,
    output logic                    RegDst,
    output logic                    MemToReg,
    output logic                    RegWrite,
    output logic                    erro_opcode,
    output logic [LARGURA_CONT-1:0] instr_count
);

    estado_t                 state_q, state_d;
    logic [LARGURA_CONT-1:0] count_q, count_d;
    logic                    retira;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (mem_pronto) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_pronto) state_d = MEMWB;
            MEMWRITE: if (mem_pronto) state_d = FETCH;
            EXECUTE:  state_d = ALUWB;
            ADDIEXEC: state_d = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // Only terminal states retire; a DECODE abort on a bad opcode does not.
    always_comb begin
        retira = 1'b0;
        case (state_q)
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: retira = 1'b1;
            MEMWRITE:                           retira = mem_pronto;
            default:                            retira = 1'b0;
        endcase
        count_d = retira ? count_q + LARGURA_CONT'(1) : count_q;
    end

    assign instr_count = count_q;

    always_comb begin
        mem_req     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        Branch      = 1'b0;
        PCSrc       = PCSRC_ALU;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_ADD;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        erro_opcode = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = SRCB_4;
                IRWrite = mem_pronto;
                PCWrite = mem_pronto;
            end
            DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: erro_opcode = 1'b0;
                    default:                                       erro_opcode = 1'b1;
                endcase
            end
            MEMADR, ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                Branch  = 1'b1;
            end
            ADDIWB:   RegWrite = 1'b1;
            JUMP: begin
                PCSrc   = PCSRC_JUMP;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        // Reset must never let a stale state touch memory, PC, IR or registers.
        if (reset) begin
            mem_req     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            Branch      = 1'b0;
            RegWrite    = 1'b0;
            erro_opcode = 1'b0;
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed per-cycle vectors for controle_multiciclo; expected outputs are hand-written
// bit patterns, packed {mem_req,MemWrite,IorD,IRWrite,PCWrite,Branch,PCSrc,ALUSrcA,ALUSrcB,ALUOp,RegDst,MemToReg,RegWrite,erro_opcode}.
module tb_controle_multiciclo;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_pronto;
    logic        mem_req, MemWrite, IorD, IRWrite, PCWrite, Branch;
    logic [1:0]  PCSrc, ALUSrcB, ALUOp;
    logic        ALUSrcA, RegDst, MemToReg, RegWrite, erro_opcode;
    logic [31:0] instr_count;

    controle_multiciclo #(.LARGURA_CONT(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_pronto(mem_pronto),
        .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .erro_opcode(erro_opcode), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {mem_req, MemWrite, IorD, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA,
                  ALUSrcB, ALUOp, RegDst, MemToReg, RegWrite, erro_opcode};

    localparam logic [16:0] E_FETCH_GO = 17'b1_0_0_1_1_0_00_0_01_00_0_0_0_0;
    localparam logic [16:0] E_FETCH_WT = 17'b1_0_0_0_0_0_00_0_01_00_0_0_0_0;
    localparam logic [16:0] E_FETCH_RS = 17'b0_0_0_0_0_0_00_0_01_00_0_0_0_0;
    localparam logic [16:0] E_DECODE   = 17'b0_0_0_0_0_0_00_0_11_00_0_0_0_0;
    localparam logic [16:0] E_DEC_ERR  = 17'b0_0_0_0_0_0_00_0_11_00_0_0_0_1;
    localparam logic [16:0] E_MEMADR   = 17'b0_0_0_0_0_0_00_1_10_00_0_0_0_0;
    localparam logic [16:0] E_MEMREAD  = 17'b1_0_1_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [16:0] E_MEMWB    = 17'b0_0_0_0_0_0_00_0_00_00_0_1_1_0;
    localparam logic [16:0] E_MEMWB_RS = 17'b0_0_0_0_0_0_00_0_00_00_0_1_0_0;
    localparam logic [16:0] E_MEMWRITE = 17'b1_1_1_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [16:0] E_MEMWR_RS = 17'b0_0_1_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [16:0] E_EXECUTE  = 17'b0_0_0_0_0_0_00_1_00_10_0_0_0_0;
    localparam logic [16:0] E_ALUWB    = 17'b0_0_0_0_0_0_00_0_00_00_1_0_1_0;
    localparam logic [16:0] E_BRANCH   = 17'b0_0_0_0_0_1_01_1_00_01_0_0_0_0;
    localparam logic [16:0] E_ADDIWB   = 17'b0_0_0_0_0_0_00_0_00_00_0_0_1_0;
    localparam logic [16:0] E_JUMP     = 17'b0_0_0_0_1_0_10_0_00_00_0_0_0_0;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100, AD = 6'b001000, JP = 6'b000010, BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        pronto;
        logic [16:0] exp_out;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic r, input logic [5:0] o, input logic p,
                       input logic [16:0] e, input logic [31:0] c);
        vec_t v;
        v.rst = r; v.op = o; v.pronto = p; v.exp_out = e; v.exp_cnt = c;
        vecs.push_back(v);
    endtask

    initial begin
        // R-type, zero wait
        add(0, R, 1, E_FETCH_GO, 0);  add(0, R, 1, E_DECODE, 0);
        add(0, R, 1, E_EXECUTE, 0);   add(0, R, 1, E_ALUWB, 0);
        // lw, three wait cycles in MEMREAD: 8 cycles total
        add(0, LW, 1, E_FETCH_GO, 1); add(0, LW, 1, E_DECODE, 1);
        add(0, LW, 1, E_MEMADR, 1);   add(0, LW, 0, E_MEMREAD, 1);
        add(0, LW, 0, E_MEMREAD, 1);  add(0, LW, 0, E_MEMREAD, 1);
        add(0, LW, 1, E_MEMREAD, 1);  add(0, LW, 1, E_MEMWB, 1);
        // beq (mem_pronto low where it must be ignored), then j
        add(0, BQ, 1, E_FETCH_GO, 2); add(0, BQ, 0, E_DECODE, 2);
        add(0, BQ, 0, E_BRANCH, 2);
        add(0, JP, 1, E_FETCH_GO, 3); add(0, JP, 1, E_DECODE, 3);
        add(0, JP, 1, E_JUMP, 3);
        // unsupported opcode, then addi
        add(0, BAD, 1, E_FETCH_GO, 4); add(0, BAD, 1, E_DEC_ERR, 4);
        add(0, AD, 1, E_FETCH_GO, 4);  add(0, AD, 1, E_DECODE, 4);
        add(0, AD, 1, E_MEMADR, 4);    add(0, AD, 1, E_ADDIWB, 4);
        // sw with two fetch wait cycles and one write wait cycle
        add(0, SW, 0, E_FETCH_WT, 5);  add(0, SW, 0, E_FETCH_WT, 5);
        add(0, SW, 1, E_FETCH_GO, 5);  add(0, SW, 1, E_DECODE, 5);
        add(0, SW, 1, E_MEMADR, 5);    add(0, SW, 0, E_MEMWRITE, 5);
        add(0, SW, 1, E_MEMWRITE, 5);
        // sw interrupted by reset in MEMWRITE while memory completes
        add(0, SW, 1, E_FETCH_GO, 6);  add(0, SW, 1, E_DECODE, 6);
        add(0, SW, 1, E_MEMADR, 6);    add(1, SW, 1, E_MEMWR_RS, 6);
        add(0, R, 1, E_FETCH_GO, 0);   add(0, R, 1, E_DECODE, 0);
        add(0, R, 1, E_EXECUTE, 0);    add(0, R, 1, E_ALUWB, 0);

        reset = 1'b1; opcode = R; mem_pronto = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(obs), 32'(E_FETCH_RS));
        chk("reset_count", instr_count, 32'd0);
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            #1;
            reset = vecs[i].rst; opcode = vecs[i].op; mem_pronto = vecs[i].pronto;
            @(negedge clk);
            chk($sformatf("row%0d_outputs", i), 32'(obs), 32'(vecs[i].exp_out));
            chk($sformatf("row%0d_count", i), instr_count, vecs[i].exp_cnt);
            @(posedge clk);
        end

        // Hand sequence: reset asserted in MEMWB must block RegWrite and clear the count.
        #1; reset = 0; opcode = LW; mem_pronto = 1;
        @(negedge clk); chk("hs_fetch", 32'(obs), 32'(E_FETCH_GO));
        chk("hs_count_before", instr_count, 32'd1);
        @(posedge clk); @(negedge clk); chk("hs_decode", 32'(obs), 32'(E_DECODE));
        @(posedge clk); @(negedge clk); chk("hs_memadr", 32'(obs), 32'(E_MEMADR));
        @(posedge clk); @(negedge clk); chk("hs_memread", 32'(obs), 32'(E_MEMREAD));
        @(posedge clk); #1; reset = 1;
        @(negedge clk); chk("hs_memwb_reset", 32'(obs), 32'(E_MEMWB_RS));
        @(posedge clk); #1; reset = 0;
        @(negedge clk); chk("hs_after_reset", 32'(obs), 32'(E_FETCH_GO));
        chk("hs_count_after", instr_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
